// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU batch executor: command encodings,
// command-word field positions, FSM states and the default batch length.
package alu_cmd_pkg;

    localparam int BATCH_LEN_DEF = 8;

    // Command word layout: [23]R, [22]C, [21:19]Addr, [18:16]Cmd, [15:8]a, [7:0]b
    localparam int F_R       = 23;
    localparam int F_C       = 22;
    localparam int F_ADDR_HI = 21;
    localparam int F_ADDR_LO = 19;
    localparam int F_CMD_HI  = 18;
    localparam int F_CMD_LO  = 16;
    localparam int F_A_LO    = 8;
    localparam int F_B_LO    = 0;

    typedef enum logic [2:0] {
        CMD_ADD = 3'd0,
        CMD_SUB = 3'd1,
        CMD_AND = 3'd2,
        CMD_OR  = 3'd3,
        CMD_XOR = 3'd4,
        CMD_MUL = 3'd5,
        CMD_SHL = 3'd6,
        CMD_CMP = 3'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU used in the second pipeline stage.
// Operands are unsigned; the result is double width.
module alu_exec_core
    import alu_cmd_pkg::*;
#(
    parameter int DW = 8
) (
    input  alu_cmd_e        cmd,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] result,
    output logic            carry,
    output logic            zero
);

    logic [DW:0]     sum;
    logic [2*DW-1:0] prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    assign zero = ~|result;

    // Result and carry selection per command
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (cmd)
            CMD_ADD: begin
                result = {{(DW-1){1'b0}}, sum};
                carry  = sum[DW];
            end
            CMD_SUB: begin
                result = {{DW{1'b0}}, a} - {{DW{1'b0}}, b};
                carry  = (a < b);
            end
            CMD_AND: result = {{DW{1'b0}}, a & b};
            CMD_OR:  result = {{DW{1'b0}}, a | b};
            CMD_XOR: result = {{DW{1'b0}}, a ^ b};
            CMD_MUL: begin
                result = prod;
                carry  = |prod[2*DW-1:DW];
            end
            CMD_SHL: result = {{DW{1'b0}}, a} << b[3:0];
            CMD_CMP: begin
                if (a > b)
                    result = {{(2*DW-1){1'b0}}, 1'b1};
                else if (a == b)
                    result = '0;
                else
                    result = '1;
                carry = (a < b);
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_batch_exec.sv
// Batch executor: accepts up to BATCH_LEN command words, executes them in a
// two-stage pipeline and stores results in an 8-entry bank for host readback.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for an alu_en rising edge
// ST_RUN   | accepting words; alu_en low aborts
// ST_DRAIN | last word retiring from stage 2
// ST_DONE  | done pulse, back to idle
module alu_batch_exec
    import alu_cmd_pkg::*;
#(
    parameter int BATCH_LEN = BATCH_LEN_DEF,
    parameter int DW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_en,
    input  logic            in_valid,
    input  logic [23:0]     in_data,
    output logic            busy,
    output logic            done,
    output logic            abort,
    output logic [7:0]      res_valid,
    input  logic            rd_en,
    input  logic [2:0]      rd_addr,
    output logic [2*DW-1:0] rd_data,
    output logic [1:0]      rd_flags
);

    localparam logic [3:0] LAST_IDX = 4'(BATCH_LEN - 1);

    state_e          state, state_n;
    logic            alu_en_q;
    logic [3:0]      count;
    logic [DW-1:0]   chain;
    logic            start, abort_n, accept;

    logic            s1_valid;
    logic [2:0]      s1_addr;
    alu_cmd_e        s1_cmd;
    logic [DW-1:0]   s1_a;
    logic [DW-1:0]   s1_b;

    logic [2*DW-1:0] ex_result;
    logic            ex_carry, ex_zero;
    logic [DW-1:0]   chain_fwd;
    logic [DW-1:0]   op_a;

    logic [2*DW-1:0] bank_res [8];
    logic [1:0]      bank_flg [8];

    assign accept    = (state == ST_RUN) && alu_en && in_valid;
    // A word retiring this cycle has not reached the chain register yet.
    assign chain_fwd = s1_valid ? ex_result[DW-1:0] : chain;
    assign op_a      = in_data[F_C] ? chain_fwd : in_data[F_A_LO +: DW];

    alu_exec_core #(.DW(DW)) u_core (
        .cmd    (s1_cmd),
        .a      (s1_a),
        .b      (s1_b),
        .result (ex_result),
        .carry  (ex_carry),
        .zero   (ex_zero)
    );

    // State register, alu_en edge history and registered abort pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            alu_en_q <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_n;
            alu_en_q <= alu_en;
            abort    <= abort_n;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        abort_n = 1'b0;
        start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (alu_en && !alu_en_q) begin
                    state_n = ST_RUN;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!alu_en) begin
                    state_n = ST_IDLE;
                    abort_n = 1'b1;
                end else if (in_valid && (count == LAST_IDX)) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Word count and chain register; both restart with each batch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            chain <= '0;
        end else if (start) begin
            count <= '0;
            chain <= '0;
        end else begin
            if (accept)
                count <= count + 1'b1;
            if (s1_valid)
                chain <= ex_result[DW-1:0];
        end
    end

    // Stage 1: capture decoded fields; only R=1 words become valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_cmd   <= CMD_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= accept && in_data[F_R];
            if (accept) begin
                s1_addr <= in_data[F_ADDR_HI:F_ADDR_LO];
                s1_cmd  <= alu_cmd_e'(in_data[F_CMD_HI:F_CMD_LO]);
                s1_a    <= op_a;
                s1_b    <= in_data[F_B_LO +: DW];
            end
        end
    end

    // Result-valid mask: cleared at batch start, set by each stage-2 write
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            res_valid <= '0;
        else if (start)
            res_valid <= '0;
        else if (s1_valid)
            res_valid[s1_addr] <= 1'b1;
    end

    // Stage 2 write into the result bank; contents are masked by res_valid
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            bank_res[s1_addr] <= ex_result;
            bank_flg[s1_addr] <= {ex_zero, ex_carry};
        end
    end

    // Registered readback; a same-edge write is not visible until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_flags <= '0;
        end else if (rd_en) begin
            if (res_valid[rd_addr]) begin
                rd_data  <= bank_res[rd_addr];
                rd_flags <= bank_flg[rd_addr];
            end else begin
                rd_data  <= '0;
                rd_flags <= '0;
            end
        end
    end

endmodule
